// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: control and display bundle between the stopwatch core and its host.
interface stopwatch_counter_if #(
    parameter int N_DIGITS = 2
);
    logic                  count_enabled;
    logic                  count_down;
    logic                  load;
    logic [4*N_DIGITS-1:0] load_value;
    logic                  lap;
    logic [4*N_DIGITS-1:0] time_reading;
    logic                  tick;
    logic                  wrapped;
    logic                  done;
    modport master (
        output count_enabled, count_down, load, load_value, lap,
        input  time_reading, tick, wrapped, done
    );
    modport slave (
        input  count_enabled, count_down, load, load_value, lap,
        output time_reading, tick, wrapped, done
    );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: N-digit BCD up/down stopwatch with prescaler, preset load, wrap/done pulses.
// Define STOPWATCH_LAP_EN to build the lap-freeze display register.
module stopwatch_counter #(
    parameter int CLK_FREQ      = 100000000,
    parameter int TICKS_PER_SEC = 1,
    parameter int N_DIGITS      = 2
) (
    input  logic                clk,
    input  logic                init_regs,
    stopwatch_counter_if.slave  sw
);
    localparam int DIV = CLK_FREQ / TICKS_PER_SEC;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W   = 4 * N_DIGITS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  dig_q, dig_d, inc, dec, clamp;
    logic          tick_q, tick_d, wrap_q, wrap_d, done_q, done_d;
    logic          step, inc_wrap, c, b;

    assign step = sw.count_enabled && (pre_q == PMAX);

    // Ripple BCD increment/decrement of the live digits; c ends high only for all-9s.
    always_comb begin
        c = 1'b1;
        b = 1'b1;
        inc = dig_q;
        dec = dig_q;
        clamp = sw.load_value;
        for (int k = 0; k < N_DIGITS; k++) begin
            inc[4*k+:4] = c ? ((dig_q[4*k+:4] == 4'd9) ? 4'd0 : dig_q[4*k+:4] + 4'd1) : dig_q[4*k+:4];
            dec[4*k+:4] = b ? ((dig_q[4*k+:4] == 4'd0) ? 4'd9 : dig_q[4*k+:4] - 4'd1) : dig_q[4*k+:4];
            c = c & (dig_q[4*k+:4] == 4'd9);
            b = b & (dig_q[4*k+:4] == 4'd0);
            clamp[4*k+:4] = (sw.load_value[4*k+:4] > 4'd9) ? 4'd9 : sw.load_value[4*k+:4];
        end
        inc_wrap = c;
    end

    always_comb begin
        pre_d = pre_q;
        dig_d = dig_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        done_d = 1'b0;
        if (sw.load) begin
            pre_d = '0;
            dig_d = clamp;
        end else if (sw.count_enabled) begin
            pre_d = step ? '0 : pre_q + 1'b1;
            tick_d = step;
            if (step && !sw.count_down) begin
                dig_d = inc;
                wrap_d = inc_wrap;
            end else if (step && dig_q != '0) begin
                dig_d = dec;
                done_d = (dec == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            pre_q <= '0;
            dig_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            dig_q <= dig_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign sw.tick    = tick_q;
    assign sw.wrapped = wrap_q;
    assign sw.done    = done_q;

`ifdef STOPWATCH_LAP_EN
    logic         lap_q;
    logic [W-1:0] cap_q;
    // lap_q doubles as the edge detector and the display select, so the frozen value shows the cycle after lap rises.
    always_ff @(posedge clk) begin
        if (init_regs) begin
            lap_q <= 1'b0;
            cap_q <= '0;
        end else begin
            lap_q <= sw.lap;
            if (sw.lap && !lap_q) cap_q <= dig_q;
        end
    end
    assign sw.time_reading = lap_q ? cap_q : dig_q;
`else
    logic unused_lap;
    assign unused_lap = sw.lap;
    assign sw.time_reading = dig_q;
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed vector table plus multi-cycle sequences for the stopwatch core (DIV=10, 2 digits).
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic init_regs;
    always #5 clk = ~clk;

    stopwatch_counter_if #(.N_DIGITS(2)) sw();
    stopwatch_counter #(.CLK_FREQ(100), .TICKS_PER_SEC(10), .N_DIGITS(2)) dut (
        .clk(clk),
        .init_regs(init_regs),
        .sw(sw)
    );

    typedef struct {
        logic       ini, en, dn, ld;
        logic [7:0] lv;
        int         n;
        logic [7:0] rd;
        logic       tk, wr, dq;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ini, input logic en, input logic dn, input logic ld, input logic [7:0] lv);
        init_regs = ini;
        sw.count_enabled = en;
        sw.count_down = dn;
        sw.load = ld;
        sw.load_value = lv;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    vec_t vt[$];
    int dcount;

    initial begin
        sw.lap = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        //        ini   en    dn    ld    lv     n   rd     tk    wr    dq
        vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3, 8'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9, 8'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h01, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h01, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 20, 8'h01, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8, 8'h01, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h02, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'hF7, 1, 8'h97, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1, 8'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1, 8'h10, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h09, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h19, 1, 8'h19, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10, 8'h20, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1, 8'h99, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10, 8'h00, 1'b1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10, 8'h01, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1, 8'h01, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h00, 1'b1, 1'b0, 1'b1});
        vt.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h00, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10, 8'h01, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5, 8'h01, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9, 8'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h01, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1, 8'h05, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5, 8'h05, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5, 8'h04, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h3A, 1, 8'h39, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9, 8'h39, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1, 8'h42, 1'b0, 1'b0, 1'b0});

        foreach (vt[i]) begin
            drive(vt[i].ini, vt[i].en, vt[i].dn, vt[i].ld, vt[i].lv);
            cyc(vt[i].n);
            chk($sformatf("v%0d.reading", i), 32'(sw.time_reading), 32'(vt[i].rd));
            chk($sformatf("v%0d.tick", i), 32'(sw.tick), 32'(vt[i].tk));
            chk($sformatf("v%0d.wrapped", i), 32'(sw.wrapped), 32'(vt[i].wr));
            chk($sformatf("v%0d.done", i), 32'(sw.done), 32'(vt[i].dq));
        end

        // Full up-count run through the 99 -> 00 rollover.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 1000; i++) begin
            cyc(1);
            chk($sformatf("up%0d.reading", i), 32'(sw.time_reading), 32'(bcd((i / 10) % 100)));
            chk($sformatf("up%0d.tick", i), 32'(sw.tick), 32'(i % 10 == 0));
            chk($sformatf("up%0d.wrapped", i), 32'(sw.wrapped), 32'(i == 1000));
        end

        // Down-count to zero and hold there with a single done pulse.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h03);
        cyc(1);
        chk("dn.load", 32'(sw.time_reading), 32'h03);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        dcount = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            if (sw.done === 1'b1) dcount++;
            chk($sformatf("dn%0d.reading", i), 32'(sw.time_reading), 32'(i >= 30 ? 0 : 3 - i / 10));
            chk($sformatf("dn%0d.done", i), 32'(sw.done), 32'(i == 30));
        end
        chk("dn.done_count", 32'(dcount), 32'd1);

        // Lap freeze while the live count keeps running.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(120);
        chk("lap.pre", 32'(sw.time_reading), 32'h12);
        sw.lap = 1'b1;
`ifdef STOPWATCH_LAP_EN
        for (int i = 1; i <= 50; i++) begin
            cyc(1);
            chk($sformatf("lap%0d.frozen", i), 32'(sw.time_reading), 32'h12);
        end
        sw.lap = 1'b0;
        cyc(1);
        chk("lap.release", 32'(sw.time_reading), 32'h17);
`else
        cyc(50);
        chk("lap.ignored", 32'(sw.time_reading), 32'h17);
        sw.lap = 1'b0;
        cyc(1);
        chk("lap.after", 32'(sw.time_reading), 32'h17);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
